// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: Q1.15 word geometry, sample types and
// saturation limits used across the butterfly stages.
package fft_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 15;

  typedef logic signed [DW-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  localparam sample_t SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DW-1){1'b0}}};

endpackage

// File: rtl/round_sat.sv
// Round-half-toward-+inf, arithmetic shift and saturate a wide product sum
// down to an OUT_W-bit signed word, flagging when the result was clipped.
module round_sat
  import fft_pkg::*;
#(
  parameter int OUT_W = DW,
  parameter int SHIFT = FRAC,
  parameter int IN_W  = 2*OUT_W+1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] RND = {{(IN_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W-1:0] HI  = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO  = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] sum_next;
  logic signed [IN_W-1:0] shr_next;

  // The input never uses its top bits fully, so adding RND cannot overflow.
  always_comb begin
    sum_next = din + RND;
    shr_next = sum_next >>> SHIFT;
    dout     = shr_next[OUT_W-1:0];
    clip     = 1'b0;
    if (shr_next > HI) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
      clip = 1'b1;
    end else if (shr_next < LO) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/twiddle_mul_stage.sv
// Three-stage Q1.15 complex multiply p = x*w with a matching delay on the
// butterfly's a operand; the shared ready enable freezes the whole pipe.
module twiddle_mul_stage #(
  parameter int DW   = fft_pkg::DW,
  parameter int FRAC = fft_pkg::FRAC
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ready,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  input  logic signed [DW-1:0] w_re,
  input  logic signed [DW-1:0] w_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] a_dly_re,
  output logic signed [DW-1:0] a_dly_im,
  output logic signed [DW-1:0] p_re,
  output logic signed [DW-1:0] p_im,
  output logic                 sat_flag
);

  localparam int PW = 2*DW;
  localparam int SW = 2*DW+1;

  // Index 0 = real, 1 = imaginary.
  logic signed [DW-1:0] a_s1_reg [2];
  logic signed [DW-1:0] x_s1_reg [2];
  logic signed [DW-1:0] w_s1_reg [2];
  logic                 v_s1_reg;

  // Products: 0 xr*wr, 1 xi*wi, 2 xr*wi, 3 xi*wr.
  logic signed [PW-1:0] prod_reg [4];
  logic signed [DW-1:0] a_s2_reg [2];
  logic                 v_s2_reg;

  logic signed [SW-1:0] full_next [2];
  logic signed [DW-1:0] rs_next   [2];
  logic                 clip_next [2];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_s1_reg[0] <= '0;
      a_s1_reg[1] <= '0;
      x_s1_reg[0] <= '0;
      x_s1_reg[1] <= '0;
      w_s1_reg[0] <= '0;
      w_s1_reg[1] <= '0;
      v_s1_reg    <= 1'b0;
    end else if (ready) begin
      a_s1_reg[0] <= a_re;
      a_s1_reg[1] <= a_im;
      x_s1_reg[0] <= x_re;
      x_s1_reg[1] <= x_im;
      w_s1_reg[0] <= w_re;
      w_s1_reg[1] <= w_im;
      v_s1_reg    <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) prod_reg[i] <= '0;
      a_s2_reg[0] <= '0;
      a_s2_reg[1] <= '0;
      v_s2_reg    <= 1'b0;
    end else if (ready) begin
      prod_reg[0] <= x_s1_reg[0] * w_s1_reg[0];
      prod_reg[1] <= x_s1_reg[1] * w_s1_reg[1];
      prod_reg[2] <= x_s1_reg[0] * w_s1_reg[1];
      prod_reg[3] <= x_s1_reg[1] * w_s1_reg[0];
      a_s2_reg    <= a_s1_reg;
      v_s2_reg    <= v_s1_reg;
    end
  end

  // One extra bit covers the worst-case sum of two full-scale products.
  always_comb begin
    full_next[0] = SW'(prod_reg[0]) - SW'(prod_reg[1]);
    full_next[1] = SW'(prod_reg[2]) + SW'(prod_reg[3]);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
      round_sat #(
        .OUT_W (DW),
        .SHIFT (FRAC),
        .IN_W  (SW)
      ) u_round_sat (
        .din  (full_next[gi]),
        .dout (rs_next[gi]),
        .clip (clip_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_re      <= '0;
      p_im      <= '0;
      a_dly_re  <= '0;
      a_dly_im  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (ready) begin
      p_re      <= rs_next[0];
      p_im      <= rs_next[1];
      a_dly_re  <= a_s2_reg[0];
      a_dly_im  <= a_s2_reg[1];
      out_valid <= v_s2_reg;
      sat_flag  <= v_s2_reg & (clip_next[0] | clip_next[1]);
    end
  end

endmodule

// File: tb/tb_twiddle_mul_stage.sv
// Scoreboard bench for twiddle_mul_stage: directed vectors push expected
// results; a monitor pops and compares every new output sample.
module tb_twiddle_mul_stage;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, ready, in_valid;
  logic signed [15:0] a_re, a_im, x_re, x_im, w_re, w_im;
  logic        out_valid, sat_flag;
  logic signed [15:0] a_dly_re, a_dly_im, p_re, p_im;

  typedef struct {
    int ar; int ai; int pr; int pi; int sat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_on   = 1'b0;

  always #5 clk = ~clk;

  twiddle_mul_stage #(.DW(DW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ready     (ready),
    .in_valid  (in_valid),
    .a_re      (a_re),
    .a_im      (a_im),
    .x_re      (x_re),
    .x_im      (x_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .out_valid (out_valid),
    .a_dly_re  (a_dly_re),
    .a_dly_im  (a_dly_im),
    .p_re      (p_re),
    .p_im      (p_im),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int xr, input int xi,
                       input int wr, input int wi, input bit v);
    @(negedge clk);
    a_re = 16'(ar); a_im = 16'(ai);
    x_re = 16'(xr); x_im = 16'(xi);
    w_re = 16'(wr); w_im = 16'(wi);
    in_valid = v;
    ready    = 1'b1;
  endtask

  task automatic send(input int ar, input int ai, input int xr, input int xi,
                      input int wr, input int wi, input int er, input int ei, input int es);
    exp_t e;
    drive(ar, ai, xr, xi, wr, wi, 1'b1);
    e.ar = ar; e.ai = ai; e.pr = er; e.pi = ei; e.sat = es;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      ready    = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_p_re"},      p_re,      0);
    chk({tag, "_p_im"},      p_im,      0);
    chk({tag, "_a_dly_re"},  a_dly_re,  0);
    chk({tag, "_a_dly_im"},  a_dly_im,  0);
    chk({tag, "_sat_flag"},  sat_flag,  0);
  endtask

  // Monitor: a new sample exists only after an enabled, non-reset edge.
  initial begin
    logic en_edge, rst_edge;
    logic signed [15:0] s_pr, s_pi, s_ar, s_ai;
    logic s_ov, s_sat;
    exp_t e;
    forever begin
      @(posedge clk);
      en_edge  = ready;
      rst_edge = resetn;
      #1;
      if (mon_on && rst_edge) begin
        if (!en_edge) begin
          chk("stall_out_valid", out_valid, s_ov);
          chk("stall_p_re",      p_re,      s_pr);
          chk("stall_p_im",      p_im,      s_pi);
          chk("stall_a_dly_re",  a_dly_re,  s_ar);
          chk("stall_a_dly_im",  a_dly_im,  s_ai);
          chk("stall_sat_flag",  sat_flag,  s_sat);
        end else if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample actual=p(%0d,%0d) a(%0d,%0d) required=no output",
                     p_re, p_im, a_dly_re, a_dly_im);
          end else begin
            e = sb.pop_front();
            $display("OUT a=(%0d,%0d) p=(%0d,%0d) sat=%0d exp p=(%0d,%0d) sat=%0d",
                     a_dly_re, a_dly_im, p_re, p_im, sat_flag, e.pr, e.pi, e.sat);
            chk("p_re",     p_re,     e.pr);
            chk("p_im",     p_im,     e.pi);
            chk("a_dly_re", a_dly_re, e.ar);
            chk("a_dly_im", a_dly_im, e.ai);
            chk("sat_flag", sat_flag, e.sat);
          end
        end else begin
          chk("bubble_sat_flag", sat_flag, 0);
        end
      end
      s_ov = out_valid; s_pr = p_re; s_pi = p_im;
      s_ar = a_dly_re;  s_ai = a_dly_im; s_sat = sat_flag;
    end
  end

  initial begin
    resetn = 1'b0; ready = 1'b1; in_valid = 1'b0;
    a_re = '0; a_im = '0; x_re = '0; x_im = '0; w_re = '0; w_im = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;
    mon_on = 1'b1;

    // Basic product and exact 3-edge latency
    send(100, -200, 16384, 0, 16384, 0, 8192, 0, 0);
    @(posedge clk); #2 chk("latency_edge1", out_valid, 0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2 chk("latency_edge2", out_valid, 0);
    @(posedge clk); #2 chk("latency_edge3", out_valid, 1);

    // Rounding, saturation and half-LSB boundaries, back to back
    send(1, 2, 0, 16384, 0, 32767, -16383, 0, 0);
    send(3, 4, -32768, 0, -32768, 0, 32767, 0, 1);
    send(5, 6, -32768, 0, 0, -32768, 0, 32767, 1);
    send(7, 8, 1, 0, 16384, 0, 1, 0, 0);
    send(9, 10, -1, 0, 16384, 0, 0, 0, 0);
    send(11, 12, 3, 0, 32767, 0, 3, 0, 0);
    idle(4);

    // Stall: ready low for 2 cycles after sample 3 enters; inputs keep sample 3
    for (int k = 1; k <= 3; k++)
      send(k, -k, 1000*k, -500*k, 16384, 16384, 750*k, 250*k, 0);
    @(negedge clk); ready = 1'b0;
    @(negedge clk); ready = 1'b0;
    for (int k = 4; k <= 6; k++)
      send(k, -k, 1000*k, -500*k, 16384, 16384, 750*k, 250*k, 0);
    idle(4);

    // Bubble carrying saturating data must not raise sat_flag
    send(21, 22, 1, 0, 16384, 0, 1, 0, 0);
    drive(0, 0, -32768, -32768, -32768, 0, 1'b0);
    send(23, 24, -1, 0, 16384, 0, 0, 0, 0);
    idle(4);

    // Reset mid-stream with ready and in_valid high: flush everything
    send(31, 32, 16384, 0, 16384, 0, 8192, 0, 0);
    send(33, 34, 16384, 0, 16384, 0, 8192, 0, 0);
    @(negedge clk);
    resetn = 1'b0; ready = 1'b1; in_valid = 1'b1;
    a_re = 16'sd35; a_im = 16'sd36;
    sb.delete();
    @(posedge clk); #2 chk_zero("midreset");
    @(negedge clk); resetn = 1'b1; in_valid = 1'b0;
    idle(5);
    send(41, 42, 16384, 16384, 16384, 0, 8192, 8192, 0);
    idle(4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2 chk("drain_queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
